// File: rtl/rev_cnt_pkg.sv
// Shared types and constants for the run/pause/clear revolution counter.
package rev_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int         REV_CNT_DIV_DEFAULT = 10_000_000;
    localparam logic [3:0] BCD_DIGIT_MAX       = 4'd9;

endpackage

// File: rtl/rev_cnt_ctrl_tick_gen.sv
// Prescaler for rev_cnt_ctrl: free-running divide-by-DIV counter.
// It only advances while en is high, and it raises step during the last cycle of each period.
module tick_gen
    import rev_cnt_pkg::*;
#(
    parameter int DIV = REV_CNT_DIV_DEFAULT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pcnt;

    assign step = en && (r_pcnt == LAST);

    // When en is low, pcnt holds its value, so the phase survives a pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (clr) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= step ? '0 : r_pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/rev_cnt_ctrl.sv
// Run/pause/clear up/down counter. It steps once every DIV clocks while running.
// Define REVCNT_BCD_EN to count as 4 packed BCD digits; this mode requires WIDTH = 16.
module rev_cnt_ctrl
    import rev_cnt_pkg::*;
#(
    parameter int DIV   = REV_CNT_DIV_DEFAULT,
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             wrap,
    output logic             running
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_load_val;
    logic             r_tick;
    logic             r_wrap;
    logic             w_step;
    logic             w_step_wrap;
    logic             w_clear;
    logic             w_pcnt_en;
    logic             w_pcnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // When start and stop are both high, stop takes priority in every state.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            IDLE:    if (start && !stop) w_state_next = RUN;
            RUN:     if (stop) w_state_next = PAUSE;
            PAUSE: begin
                if (stop) begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                end else if (start) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A stop in RUN freezes the prescaler, which also swallows a step that was due.
    assign w_pcnt_en  = (r_state == RUN) && !stop;
    assign w_pcnt_clr = load || w_clear || (r_state == IDLE);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pcnt_en),
        .clr   (w_pcnt_clr),
        .step  (w_step)
    );

`ifdef REVCNT_BCD_EN
    logic [3:0] w_lim;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        localparam logic [3:0] LOWER = 4'((1 << gi) - 1);
        logic [3:0] w_dig;
        logic [3:0] w_ld;
        logic       w_ripple;

        assign w_dig     = r_cnt[4*gi +: 4];
        assign w_lim[gi] = dir ? (w_dig >= BCD_DIGIT_MAX) : (w_dig == 4'd0);
        // This digit moves only when every lower digit is about to carry or borrow.
        assign w_ripple  = ((w_lim & LOWER) == LOWER);
        assign w_cnt_step[4*gi +: 4] = !w_ripple ? w_dig :
                                       w_lim[gi] ? (dir ? 4'd0 : BCD_DIGIT_MAX) :
                                       (dir ? w_dig + 4'd1 : w_dig - 4'd1);
        assign w_ld = load_val[4*gi +: 4];
        assign w_load_val[4*gi +: 4] = (w_ld > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : w_ld;
    end

    assign w_step_wrap = &w_lim;
`else
    assign w_cnt_step  = dir ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
    assign w_step_wrap = dir ? (&r_cnt) : (~|r_cnt);
    assign w_load_val  = load_val;
`endif

    // Priority order is clear, then load, then step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (w_clear) begin
                r_cnt <= '0;
            end else if (load) begin
                r_cnt <= w_load_val;
            end else if (w_step) begin
                r_cnt  <= w_cnt_step;
                r_tick <= 1'b1;
                r_wrap <= w_step_wrap;
            end
        end
    end

    assign cnt     = r_cnt;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_rev_cnt_ctrl.sv
// Table-driven scoreboard bench for rev_cnt_ctrl (DIV=4, WIDTH=16).
// When REVCNT_BCD_EN is defined, the bench runs the BCD vectors instead of the binary ones.
module tb_rev_cnt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] cnt;
    logic        tick;
    logic        wrap;
    logic        running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        dir;
        logic        load;
        logic [15:0] lv;
        logic [15:0] e_cnt;
        logic        e_tick;
        logic        e_wrap;
        logic        e_run;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] cnt;
        logic        tick;
        logic        wrap;
        logic        run;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rev_cnt_ctrl #(
        .DIV   (4),
        .WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, idx, got, want);
        end
    endfunction

    function automatic void add(input logic st, input logic sp, input logic d, input logic ld,
                                input logic [15:0] lv, input logic [15:0] ec,
                                input logic et, input logic ew, input logic er);
        vec_t v;
        v.start = st; v.stop = sp; v.dir = d; v.load = ld; v.lv = lv;
        v.e_cnt = ec; v.e_tick = et; v.e_wrap = ew; v.e_run = er;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input int n, input logic d, input logic [15:0] ec, input logic er);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, d, 1'b0, 16'h0, ec, 1'b0, 1'b0, er);
    endfunction

    function automatic void build_bin_table();
        // Start, then steps 1, 2, 3 arrive every 4 cycles.
        add(1, 0, 1, 0, 16'h0, 16'h0000, 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            idle(3, 1, 16'(k - 1), 1);
            add(0, 0, 1, 0, 16'h0, 16'(k), 1, 0, 1);
        end
        // Up-wrap from all-ones, down-wrap from zero, then a plain down step.
        add(0, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0, 1);
        idle(3, 1, 16'hFFFF, 1);
        add(0, 0, 1, 0, 16'h0, 16'h0000, 1, 1, 1);
        idle(3, 0, 16'h0000, 1);
        add(0, 0, 0, 0, 16'h0, 16'hFFFF, 1, 1, 1);
        idle(3, 0, 16'hFFFF, 1);
        add(0, 0, 0, 0, 16'h0, 16'hFFFE, 1, 0, 1);
        // Pause at pcnt=2, hold 20 cycles, resume: the step lands 2 cycles later.
        idle(2, 1, 16'hFFFE, 1);
        add(0, 1, 1, 0, 16'h0, 16'hFFFE, 0, 0, 0);
        idle(20, 1, 16'hFFFE, 0);
        add(1, 0, 1, 0, 16'h0, 16'hFFFE, 0, 0, 1);
        add(0, 0, 1, 0, 16'h0, 16'hFFFE, 0, 0, 1);
        add(0, 0, 1, 0, 16'h0, 16'hFFFF, 1, 0, 1);
        // Stop twice to clear into IDLE.
        add(0, 1, 1, 0, 16'h0, 16'hFFFF, 0, 0, 0);
        add(0, 0, 1, 0, 16'h0, 16'hFFFF, 0, 0, 0);
        add(0, 1, 1, 0, 16'h0, 16'h0000, 0, 0, 0);
        add(1, 1, 1, 0, 16'h0, 16'h0000, 0, 0, 0);
        // Load on a step cycle: the load wins, and the next step comes 4 cycles later.
        add(1, 0, 1, 0, 16'h0, 16'h0000, 0, 0, 1);
        idle(3, 1, 16'h0000, 1);
        add(0, 0, 1, 1, 16'h1234, 16'h1234, 0, 0, 1);
        idle(3, 1, 16'h1234, 1);
        add(0, 0, 1, 0, 16'h0, 16'h1235, 1, 0, 1);
        // Stop on a pending step suppresses it; resume steps right away.
        idle(3, 1, 16'h1235, 1);
        add(0, 1, 1, 0, 16'h0, 16'h1235, 0, 0, 0);
        add(1, 0, 1, 0, 16'h0, 16'h1235, 0, 0, 1);
        add(0, 0, 1, 0, 16'h0, 16'h1236, 1, 0, 1);
        // start+stop: stop wins; the clear beats a coincident load; IDLE never ticks.
        add(1, 1, 1, 0, 16'h0, 16'h1236, 0, 0, 0);
        add(1, 1, 1, 1, 16'h5555, 16'h0000, 0, 0, 0);
        add(1, 1, 1, 0, 16'h0, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 1, 16'hABCD, 16'hABCD, 0, 0, 0);
        idle(6, 1, 16'hABCD, 0);
    endfunction

    function automatic void build_bcd_table();
        add(0, 0, 1, 1, 16'h0999, 16'h0999, 0, 0, 0);
        add(1, 0, 1, 0, 16'h0, 16'h0999, 0, 0, 1);
        idle(3, 1, 16'h0999, 1);
        add(0, 0, 1, 0, 16'h0, 16'h1000, 1, 0, 1);
        add(0, 0, 1, 1, 16'h9999, 16'h9999, 0, 0, 1);
        idle(3, 1, 16'h9999, 1);
        add(0, 0, 1, 0, 16'h0, 16'h0000, 1, 1, 1);
        add(0, 0, 0, 1, 16'hABCD, 16'h9999, 0, 0, 1);
        idle(3, 0, 16'h9999, 1);
        add(0, 0, 0, 0, 16'h0, 16'h9998, 1, 0, 1);
        add(0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 1);
        idle(3, 0, 16'h0100, 1);
        add(0, 0, 0, 0, 16'h0, 16'h0099, 1, 0, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
        idle(3, 0, 16'h0000, 1);
        add(0, 0, 0, 0, 16'h0, 16'h9999, 1, 1, 1);
        add(0, 0, 1, 1, 16'h1A09, 16'h1909, 0, 0, 1);
    endfunction

    task automatic run_table();
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            start    = tbl[i].start;
            stop     = tbl[i].stop;
            dir      = tbl[i].dir;
            load     = tbl[i].load;
            load_val = tbl[i].lv;
            e.idx  = i;
            e.cnt  = tbl[i].e_cnt;
            e.tick = tbl[i].e_tick;
            e.wrap = tbl[i].e_wrap;
            e.run  = tbl[i].e_run;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", i, 16'd0, 16'd1);
            end else begin
                e = sb.pop_front();
                chk("cnt", e.idx, cnt, e.cnt);
                chk("tick", e.idx, {15'd0, tick}, {15'd0, e.tick});
                chk("wrap", e.idx, {15'd0, wrap}, {15'd0, e.wrap});
                chk("running", e.idx, {15'd0, running}, {15'd0, e.run});
                $display("row %0d st=%b sp=%b dir=%b ld=%b cnt=%h tick=%b wrap=%b run=%b",
                         e.idx, start, stop, dir, load, cnt, tick, wrap, running);
            end
        end
        start = 1'b0; stop = 1'b0; load = 1'b0; load_val = '0; dir = 1'b1;
    endtask

    initial begin
`ifdef REVCNT_BCD_EN
        build_bcd_table();
`else
        build_bin_table();
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", -1, cnt, 16'h0);
        chk("rst_tick", -1, {15'd0, tick}, 16'h0);
        chk("rst_wrap", -1, {15'd0, wrap}, 16'h0);
        chk("rst_running", -1, {15'd0, running}, 16'h0);
        $display("reset cnt=%h tick=%b wrap=%b run=%b", cnt, tick, wrap, running);
        rst_n = 1'b1;

        run_table();
        chk("sb_drained", -1, 16'(sb.size()), 16'd0);

        // Asynchronous reset asserted mid-run, away from any clock edge.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_running", -2, {15'd0, running}, 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async_cnt", -2, cnt, 16'h0);
        chk("async_tick", -2, {15'd0, tick}, 16'h0);
        chk("async_wrap", -2, {15'd0, wrap}, 16'h0);
        chk("async_running", -2, {15'd0, running}, 16'h0);
        $display("async reset cnt=%h tick=%b wrap=%b run=%b", cnt, tick, wrap, running);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_tick", 1000 + c, {15'd0, tick}, 16'h0);
            chk("post_rst_running", 1000 + c, {15'd0, running}, 16'h0);
            chk("post_rst_cnt", 1000 + c, cnt, 16'h0);
            $display("post-reset cycle %0d cnt=%h tick=%b run=%b", c, cnt, tick, running);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rev_cnt_ctrl.md
REV_CNT_CTRL -- requirements
Module: rev_cnt_ctrl

Interface
REQ-001 Parameter DIV, default 10_000_000, clk cycles per count step (100 ms at 100 MHz); legal range 2..2^26.
REQ-002 Parameter WIDTH, default 16, counter width in bits; exactly 16 when REVCNT_BCD_EN is defined.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level, sampled each cycle; run request.
REQ-006 stop  input  1  level, sampled each cycle; pause, then clear, request.
REQ-007 dir  input  1  1 = count up, 0 = count down; sampled on the step cycle.
REQ-008 load  input  1  one-cycle strobe; load load_val.
REQ-009 load_val  input  WIDTH  value written to cnt on load.
REQ-010 cnt  output  WIDTH  registered counter value.
REQ-011 tick  output  1  registered one-cycle pulse, high in the cycle after each count step.
REQ-012 wrap  output  1  registered one-cycle pulse, high in the cycle after a step that wrapped.
REQ-013 running  output  1  high iff the FSM is in RUN, decoded from the state register.

Function
REQ-014 FSM states: IDLE, RUN, PAUSE.
REQ-015 FSM transitions: IDLE+start -> RUN; RUN+stop -> PAUSE; PAUSE+start -> RUN; PAUSE+stop -> IDLE; all other cases hold state.
REQ-016 start and stop high in the same cycle: stop wins.
REQ-017 Entering IDLE from PAUSE clears cnt and the prescaler to 0.
REQ-018 Prescaler pcnt is a free counter: it increments once per cycle in RUN, holds in PAUSE (phase preserved), and stays at 0 in IDLE.
REQ-019 When pcnt == DIV-1 in RUN: next edge sets pcnt to 0, steps cnt by ±1 according to dir, and sets tick to 1 for exactly one cycle.
REQ-020 First step occurs on the DIV-th rising edge after the edge that entered RUN.
REQ-021 Binary mode: cnt wraps modulo 2^WIDTH; up from all-ones gives 0, down from 0 gives all-ones.
REQ-022 wrap is asserted together with tick on any wrapping step, and is 0 otherwise.
REQ-023 load is accepted in any state: cnt <= load_val and pcnt <= 0; FSM state is unchanged.
REQ-024 load coinciding with a step: load wins; no step occurs and tick/wrap stay 0.
REQ-025 load coinciding with the PAUSE->IDLE clear: the clear wins.
REQ-026 stop asserted in the same cycle as a pending step (pcnt == DIV-1): the step is suppressed and pcnt holds.

Reset
REQ-027 On rst_n low, immediately and asynchronously: state IDLE, cnt 0, pcnt 0, tick 0, wrap 0 (so running = 0).
REQ-028 Reset deasserted mid-count: operation resumes from IDLE; no tick is produced until start has been asserted and DIV further cycles have elapsed.

Configuration
REQ-029 Macro REVCNT_BCD_EN defined: cnt is 4 packed BCD digits ranging 0000..9999 (hex 0x0000..0x9999), with per-digit carry and borrow.
REQ-030 With REVCNT_BCD_EN: up from 9999 gives 0000 with wrap; down from 0000 gives 9999 with wrap.
REQ-031 With REVCNT_BCD_EN: a load_val containing any nibble > 9 is saturated per nibble to 9.
REQ-032 Macro REVCNT_BCD_EN undefined: pure binary behaviour per REQ-021, and no BCD logic is synthesized.

Structure
REQ-033 Shared package rev_cnt_pkg holds the FSM state enum (IDLE/RUN/PAUSE), the DIV default constant, and the BCD digit maximum constant (9).
REQ-034 Prescaler is a sub-module tick_gen (parameter DIV; inputs clk, rst_n, en, clr; output step pulse); the FSM and counter remain in rev_cnt_ctrl.

Verification (bench uses DIV=4, binary WIDTH=16 unless stated)
REQ-035 Reset, then start pulsed at cycle 0 -> running=1; tick at cycles 5, 9, 13; cnt reads 1, 2, 3.
REQ-036 load_val=0xFFFF loaded, dir=1, RUN -> next step cnt=0x0000 with tick=wrap=1 for one cycle; then dir=0 -> next step cnt=0xFFFF with wrap=1.
REQ-037 RUN with pcnt=2, stop pulsed -> PAUSE, cnt frozen for 20 cycles; start pulsed -> next tick after 2 cycles (phase preserved); stop pulsed twice -> IDLE, cnt=0.
REQ-038 load (load_val=0x1234) asserted exactly on a step cycle -> cnt=0x1234, tick=0; next step occurs 4 cycles later.
REQ-039 rst_n pulled low mid-RUN at a non-edge time -> all outputs 0 immediately; after release, no tick without start.
REQ-040 REVCNT_BCD_EN build: load 0x0999, dir=1 -> step gives 0x1000; load 0x9999, dir=1 -> step gives 0x0000 with wrap; load 0xABCD -> cnt=0x9999.
